// File: rtl/io_channel_ctrl.sv
// Input/output channel sequencer: loader fills the input buffer, the core
// consumes it with in/inSize and writes a circular output buffer for readback.
module io_channel_ctrl #(
    parameter int unsigned MemoryElementWidth = 12,
    parameter int unsigned NIn                = 8,
    parameter int unsigned NOut               = 8,
    localparam int unsigned OW = (NOut > 1) ? $clog2(NOut) : 1
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          load_valid,
    input  logic [MemoryElementWidth-1:0] load_data,
    output logic                          load_ready,
    output logic                          load_overflow,
    input  logic                          start,
    input  logic                          halt,
    input  logic                          in_req,
    output logic                          in_ack,
    output logic [MemoryElementWidth-1:0] in_data,
    output logic                          in_empty,
    output logic [MemoryElementWidth-1:0] in_size,
    input  logic                          out_valid,
    input  logic [MemoryElementWidth-1:0] out_data,
    output logic [OW-1:0]                 out_pos,
    input  logic [OW-1:0]                 rd_addr,
    output logic [MemoryElementWidth-1:0] rd_data,
    output logic [1:0]                    state
);

    localparam int unsigned MW = MemoryElementWidth;
    localparam int unsigned CW = $clog2(NIn + 1);
    localparam int unsigned IW = (NIn > 1) ? $clog2(NIn) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   rd_pos_q, rd_pos_d;
    logic [OW-1:0]   out_pos_q, out_pos_d;
    logic            overflow_q, overflow_d;
    logic            in_ack_q, in_ack_d;
    logic            in_empty_q, in_empty_d;
    logic [MW-1:0]   in_data_q, in_data_d;
    logic [MW-1:0]   rd_data_q, rd_data_d;
    logic            loading_c, load_fire_c, out_wr_c;

    logic [MW-1:0]   in_mem  [NIn];
    logic [MW-1:0]   out_mem [NOut];

    assign loading_c   = (state_q == IDLE) || (state_q == LOAD);
    assign load_ready  = loading_c && (32'(count_q) < NIn);
    assign load_fire_c = load_valid && load_ready;
    assign out_wr_c    = (state_q == RUN) && out_valid;

    // Next-state, channel bookkeeping and readback selection
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        rd_pos_d   = rd_pos_q;
        out_pos_d  = out_pos_q;
        overflow_d = overflow_q;
        in_ack_d   = 1'b0;
        in_empty_d = in_empty_q;
        in_data_d  = in_data_q;
        rd_data_d  = '0;

        case (state_q)
            IDLE: begin
                if (halt)            state_d = DONE;
                else if (start)      state_d = RUN;
                else if (load_valid) state_d = LOAD;
            end
            LOAD: begin
                if (halt)       state_d = DONE;
                else if (start) state_d = RUN;
            end
            RUN: begin
                if (halt) state_d = DONE;
            end
            default: state_d = DONE;
        endcase

        if (load_fire_c) count_d = count_q + CW'(1);
        if (loading_c && load_valid && !load_ready) overflow_d = 1'b1;

        if ((state_q == RUN) && in_req) begin
            in_ack_d = 1'b1;
            if (rd_pos_q < count_q) begin
                in_data_d  = in_mem[IW'(rd_pos_q)];
                in_empty_d = 1'b0;
                rd_pos_d   = rd_pos_q + CW'(1);
            end else begin
                in_empty_d = 1'b1;
            end
        end

        if (out_wr_c) begin
            if (32'(out_pos_q) == NOut - 1) out_pos_d = '0;
            else                            out_pos_d = out_pos_q + OW'(1);
        end

        if (32'(rd_addr) < NOut) rd_data_d = out_mem[rd_addr];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            count_q    <= '0;
            rd_pos_q   <= '0;
            out_pos_q  <= '0;
            overflow_q <= 1'b0;
            in_ack_q   <= 1'b0;
            in_empty_q <= 1'b0;
            in_data_q  <= '0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            rd_pos_q   <= rd_pos_d;
            out_pos_q  <= out_pos_d;
            overflow_q <= overflow_d;
            in_ack_q   <= in_ack_d;
            in_empty_q <= in_empty_d;
            in_data_q  <= in_data_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // Buffer storage survives reset; only the bookkeeping is cleared
    always_ff @(posedge clock) begin
        if (load_fire_c) in_mem[IW'(count_q)] <= load_data;
        if (out_wr_c)    out_mem[out_pos_q]   <= out_data;
    end

    assign state         = state_q;
    assign load_overflow = overflow_q;
    assign in_ack        = in_ack_q;
    assign in_empty      = in_empty_q;
    assign in_data       = in_data_q;
    assign in_size       = MW'(count_q - rd_pos_q);
    assign out_pos       = out_pos_q;
    assign rd_data       = rd_data_q;

endmodule

// File: tb/tb_io_channel_ctrl.sv
// Directed bench for io_channel_ctrl with a 2-deep input and 5-deep output buffer.
module tb_io_channel_ctrl;

    localparam int unsigned MW = 12;
    localparam int unsigned OW = 3;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          load_valid, start, halt, in_req, out_valid;
    logic [MW-1:0] load_data, out_data;
    logic          load_ready, load_overflow, in_ack, in_empty;
    logic [MW-1:0] in_data, in_size, rd_data;
    logic [OW-1:0] out_pos, rd_addr;
    logic [1:0]    state;

    int n_cmp = 0;
    int n_err = 0;

    io_channel_ctrl #(.MemoryElementWidth(MW), .NIn(2), .NOut(5)) dut (
        .clock(clock), .reset_n(reset_n),
        .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
        .load_overflow(load_overflow), .start(start), .halt(halt),
        .in_req(in_req), .in_ack(in_ack), .in_data(in_data), .in_empty(in_empty),
        .in_size(in_size), .out_valid(out_valid), .out_data(out_data),
        .out_pos(out_pos), .rd_addr(rd_addr), .rd_data(rd_data), .state(state)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        load_valid = 0; start = 0; halt = 0; in_req = 0; out_valid = 0;
        load_data = '0; out_data = '0;
    endtask

    logic [MW-1:0] exp_rb [5];

    initial begin
        idle_inputs();
        rd_addr = '0;
        reset_n = 0;
        #3;
        chk("rst_state", state, 0);
        chk("rst_load_ready", load_ready, 1);
        chk("rst_overflow", load_overflow, 0);
        chk("rst_in_ack", in_ack, 0);
        chk("rst_in_empty", in_empty, 0);
        chk("rst_in_data", in_data, 0);
        chk("rst_in_size", in_size, 0);
        chk("rst_out_pos", out_pos, 0);
        chk("rst_rd_data", rd_data, 0);
        reset_n = 1;

        // load 88, 44 then start
        load_valid = 1; load_data = 88; step();
        chk("ld1_state", state, 1);
        chk("ld1_size", in_size, 1);
        load_data = 44; step();
        chk("ld2_size", in_size, 2);
        chk("ld2_ready", load_ready, 0);
        load_valid = 0; start = 1; step();
        start = 0;
        chk("start_state", state, 2);
        chk("run_size0", in_size, 2);

        in_req = 1; step();
        in_req = 0;
        chk("req1_ack", in_ack, 1);
        chk("req1_data", in_data, 88);
        chk("req1_empty", in_empty, 0);
        chk("req1_size", in_size, 1);
        step();
        chk("gap_ack", in_ack, 0);
        chk("gap_size", in_size, 1);
        in_req = 1; step();
        chk("req2_ack", in_ack, 1);
        chk("req2_data", in_data, 44);
        chk("req2_empty", in_empty, 0);
        chk("req2_size", in_size, 0);
        step();
        in_req = 0;
        chk("req3_ack", in_ack, 1);
        chk("req3_empty", in_empty, 1);
        chk("req3_data", in_data, 44);
        chk("req3_size", in_size, 0);

        // output writes 88,44,2,1,0 fill all five slots and wrap out_pos
        exp_rb = '{12'd88, 12'd44, 12'd2, 12'd1, 12'd0};
        for (int i = 0; i < 5; i++) begin
            out_valid = 1; out_data = exp_rb[i]; step();
        end
        out_valid = 0;
        chk("wr5_out_pos", out_pos, 0);
        for (int i = 0; i < 5; i++) begin
            rd_addr = OW'(i); step();
            chk($sformatf("rb_a_%0d", i), rd_data, exp_rb[i]);
        end
        rd_addr = 3'd5; step();
        chk("rb_oob5", rd_data, 0);
        rd_addr = 3'd7; step();
        chk("rb_oob7", rd_data, 0);

        // simultaneous empty request and output write
        in_req = 1; out_valid = 1; out_data = 77; rd_addr = 0; step();
        in_req = 0; out_valid = 0;
        chk("both_ack", in_ack, 1);
        chk("both_empty", in_empty, 1);
        chk("both_out_pos", out_pos, 1);
        step();
        chk("both_rb0", rd_data, 77);

        // wrap: 10..15 from slot 1 -> slots 0..4 = 14,15,11,12,13
        for (int i = 0; i < 6; i++) begin
            out_valid = 1; out_data = MW'(10 + i); step();
        end
        out_valid = 0;
        chk("wrap_out_pos", out_pos, 2);
        exp_rb = '{12'd14, 12'd15, 12'd11, 12'd12, 12'd13};
        for (int i = 0; i < 5; i++) begin
            rd_addr = OW'(i); step();
            chk($sformatf("rb_w_%0d", i), rd_data, exp_rb[i]);
        end

        // load in RUN ignored silently
        load_valid = 1; load_data = 9; step();
        load_valid = 0;
        chk("runld_size", in_size, 0);
        chk("runld_ovf", load_overflow, 0);

        // request sampled on halt edge still acked, in DONE
        in_req = 1; halt = 1; step();
        in_req = 0; halt = 0;
        chk("halt_state", state, 3);
        chk("halt_ack", in_ack, 1);
        in_req = 1; out_valid = 1; out_data = 99; step();
        in_req = 0; out_valid = 0;
        chk("done_no_ack", in_ack, 0);
        chk("done_out_pos", out_pos, 2);
        chk("done_state", state, 3);

        // overflow: loads 1,2,3 with NIn=2
        reset_n = 0; #1;
        chk("rst2_state", state, 0);
        reset_n = 1;
        load_valid = 1; load_data = 1; step();
        chk("ov1_ready", load_ready, 1);
        load_data = 2; step();
        chk("ov2_ready", load_ready, 0);
        chk("ov2_ovf", load_overflow, 0);
        load_data = 3; step();
        load_valid = 0;
        chk("ov3_ovf", load_overflow, 1);
        chk("ov3_size", in_size, 2);
        start = 1; step();
        start = 0;
        in_req = 1; step();
        chk("ov_req1_data", in_data, 1);
        step();
        in_req = 0;
        chk("ov_req2_data", in_data, 2);
        chk("ov_req2_size", in_size, 0);
        chk("ov_sticky", load_overflow, 1);

        // async reset clears overflow immediately
        reset_n = 0; #1;
        chk("rst3_ovf", load_overflow, 0);
        chk("rst3_state", state, 0);
        reset_n = 1;

        // start with load in IDLE: load counted, enters RUN
        load_valid = 1; load_data = 6; start = 1; step();
        load_valid = 0; start = 0;
        chk("stld_state", state, 2);
        chk("stld_size", in_size, 1);
        in_req = 1; out_valid = 1; out_data = 33; rd_addr = 0; step();
        out_valid = 0;
        chk("stld_ack", in_ack, 1);
        chk("stld_data", in_data, 6);
        chk("stld_empty", in_empty, 0);
        chk("stld_out_pos", out_pos, 1);

        // reset lands before the edge that would sample in_req: no ack ever
        #2; reset_n = 0; #1;
        chk("abort_ack", in_ack, 0);
        chk("abort_state", state, 0);
        chk("abort_size", in_size, 0);
        chk("abort_out_pos", out_pos, 0);
        chk("abort_ovf", load_overflow, 0);
        chk("abort_rd", rd_data, 0);
        step();
        reset_n = 1; step();
        in_req = 0;
        chk("post_rst_ack", in_ack, 0);
        chk("post_rst_state", state, 0);
        chk("keep_buf_rb0", rd_data, 33);

        // halt straight from IDLE
        halt = 1; step();
        halt = 0;
        chk("idle_halt", state, 3);
        chk("done_ready", load_ready, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
